// File: rtl/usb_proxy_pkg.sv
// Shared definitions for the full-speed USB proxy: the direction-arbiter state
// encoding, the bus line states and the line decoder used by the datapath too.
package usb_proxy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FWD_DOWN = 3'd1,
    ST_EOP_DOWN = 3'd2,
    ST_FWD_UP   = 3'd3,
    ST_EOP_UP   = 3'd4,
    ST_TURN     = 3'd5,
    ST_BUS_RST  = 3'd6
  } state_e;

  // Line states encoded as {dp, dm}; SE1 is decoded as neither K nor SE0.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_e;

  function automatic line_e decode_line(input logic dp, input logic dm);
    return line_e'({dp, dm});
  endfunction

endpackage

// File: rtl/usb_line_sync.sv
// SYNC_STAGES-deep synchroniser for one raw D+/D- pair. Resets to the idle J
// state so the arbiter sees a quiet bus while the chain refills.
module usb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic dp_i,
  input  logic dm_i,
  output logic dp_o,
  output logic dm_o
);

  logic [SYNC_STAGES-1:0] dp_q;
  logic [SYNC_STAGES-1:0] dm_q;

  // Shift each raw line through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q <= '1;
      dm_q <= '0;
    end else begin
      dp_q[0] <= dp_i;
      dm_q[0] <= dm_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dp_q[i] <= dp_q[i-1];
        dm_q[i] <= dm_q[i-1];
      end
    end
  end

  assign dp_o = dp_q[SYNC_STAGES-1];
  assign dm_o = dm_q[SYNC_STAGES-1];

endmodule

// File: rtl/usb_dir_arbiter.sv
// Direction arbiter for the full-speed USB proxy: decides which side owns the
// wire and sequences the forwarding output-enables. All outputs are registered
// copies of the state decode. Optional packet statistics are enabled by
// defining USB_DIR_ARBITER_STATS_EN.
module usb_dir_arbiter
  import usb_proxy_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER       = 2,
  parameter int SE0_MIN      = 3,
  parameter int EOP_HOLD     = 4,
  parameter int TURN_CYCLES  = 8,
  parameter int RESET_CYCLES = 125,
  parameter int MAX_PKT      = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_dp_i,
  input  logic       host_dm_i,
  input  logic       dev_dp_i,
  input  logic       dev_dm_i,
  output logic       oe_down,
  output logic       oe_up,
  output logic       busy,
  output logic       bus_reset,
  output logic       err_timeout,
  output logic [2:0] state_o
`ifdef USB_DIR_ARBITER_STATS_EN
  ,
  output logic [15:0] pkt_down_cnt,
  output logic [15:0] pkt_up_cnt
`endif
);

  localparam int RUN_MAX = (RESET_CYCLES > SE0_MIN) ? RESET_CYCLES : SE0_MIN;
  localparam int TMR_MAX = (EOP_HOLD > TURN_CYCLES) ? EOP_HOLD : TURN_CYCLES;
  localparam int FLT_W   = $clog2(FILTER + 1);
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PKT_W   = $clog2(MAX_PKT + 1);

  logic  h_dp, h_dm, d_dp, d_dm;
  line_e h_line, d_line;
  logic  h_k, h_j, h_se0, d_k, d_j, d_se0;

  state_e           state_q, state_d;
  logic [FLT_W-1:0] flt_host_q, flt_host_d, flt_dev_q, flt_dev_d;
  logic [RUN_W-1:0] se0_host_q, se0_host_d, se0_dev_q, se0_dev_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic             abort_q, abort_d;
  logic             host_qual, dev_qual, host_rst_hit, in_fwd;

  usb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_host_sync (
    .clk  (clk),
    .rst  (rst),
    .dp_i (host_dp_i),
    .dm_i (host_dm_i),
    .dp_o (h_dp),
    .dm_o (h_dm)
  );

  usb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dev_sync (
    .clk  (clk),
    .rst  (rst),
    .dp_i (dev_dp_i),
    .dm_i (dev_dm_i),
    .dp_o (d_dp),
    .dm_o (d_dm)
  );

  assign h_line = decode_line(h_dp, h_dm);
  assign d_line = decode_line(d_dp, d_dm);
  assign h_k    = (h_line == LINE_K);
  assign h_j    = (h_line == LINE_J);
  assign h_se0  = (h_line == LINE_SE0);
  assign d_k    = (d_line == LINE_K);
  assign d_j    = (d_line == LINE_J);
  assign d_se0  = (d_line == LINE_SE0);

  // The sample that completes a qualifying run decides this cycle's transition.
  assign host_qual    = h_k && (flt_host_q == FLT_W'(FILTER - 1));
  assign dev_qual     = d_k && (flt_dev_q == FLT_W'(FILTER - 1));
  assign host_rst_hit = h_se0 && (se0_host_q == RUN_W'(RESET_CYCLES - 1));
  assign in_fwd       = (state_q == ST_FWD_DOWN) || (state_q == ST_FWD_UP);

  // Next-state logic: start filters, EOP detection, bus reset and timeout abort.
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host_qual)         state_d = ST_FWD_DOWN;
        else if (dev_qual)     state_d = ST_FWD_UP;
        else if (host_rst_hit) state_d = ST_BUS_RST;
      end
      ST_FWD_DOWN: begin
        if (host_rst_hit) begin
          state_d = ST_BUS_RST;
        end else if (h_j && (se0_host_q >= RUN_W'(SE0_MIN))) begin
          state_d = ST_EOP_DOWN;
        end else if (pkt_q == PKT_W'(MAX_PKT - 1)) begin
          state_d = ST_TURN;
          abort_d = 1'b1;
        end
      end
      ST_FWD_UP: begin
        if (d_j && (se0_dev_q >= RUN_W'(SE0_MIN))) begin
          state_d = ST_EOP_UP;
        end else if (pkt_q == PKT_W'(MAX_PKT - 1)) begin
          state_d = ST_TURN;
          abort_d = 1'b1;
        end
      end
      ST_EOP_DOWN, ST_EOP_UP: begin
        if (tmr_q == TMR_W'(EOP_HOLD - 1)) state_d = ST_TURN;
      end
      ST_TURN: begin
        if (tmr_q == TMR_W'(TURN_CYCLES - 1)) state_d = ST_IDLE;
      end
      ST_BUS_RST: begin
        if (h_j) state_d = ST_TURN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter next values: saturating, cleared outside the states that use them.
  always_comb begin
    flt_host_d = '0;
    flt_dev_d  = '0;
    se0_host_d = '0;
    se0_dev_d  = '0;
    tmr_d      = '0;
    pkt_d      = '0;
    if (state_q == ST_IDLE && h_k)
      flt_host_d = (flt_host_q == FLT_W'(FILTER)) ? flt_host_q : flt_host_q + 1'b1;
    if (state_q == ST_IDLE && d_k)
      flt_dev_d = (flt_dev_q == FLT_W'(FILTER)) ? flt_dev_q : flt_dev_q + 1'b1;
    if ((state_q == ST_IDLE || state_q == ST_FWD_DOWN) && h_se0)
      se0_host_d = (se0_host_q == RUN_W'(RUN_MAX)) ? se0_host_q : se0_host_q + 1'b1;
    if (state_q == ST_FWD_UP && d_se0)
      se0_dev_d = (se0_dev_q == RUN_W'(RUN_MAX)) ? se0_dev_q : se0_dev_q + 1'b1;
    if (state_d == state_q)
      tmr_d = (tmr_q == TMR_W'(TMR_MAX)) ? tmr_q : tmr_q + 1'b1;
    if (state_d == state_q && in_fwd)
      pkt_d = (pkt_q == PKT_W'(MAX_PKT)) ? pkt_q : pkt_q + 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flt_host_q <= '0;
      flt_dev_q  <= '0;
      se0_host_q <= '0;
      se0_dev_q  <= '0;
      tmr_q      <= '0;
      pkt_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      flt_host_q <= flt_host_d;
      flt_dev_q  <= flt_dev_d;
      se0_host_q <= se0_host_d;
      se0_dev_q  <= se0_dev_d;
      tmr_q      <= tmr_d;
      pkt_q      <= pkt_d;
      abort_q    <= abort_d;
    end
  end

  // Registered outputs decoded from the current state; the abort pulse is
  // delayed one cycle so it lines up with the enable dropping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_down     <= 1'b0;
      oe_up       <= 1'b0;
      busy        <= 1'b0;
      bus_reset   <= 1'b0;
      err_timeout <= 1'b0;
      state_o     <= 3'd0;
    end else begin
      oe_down     <= (state_q == ST_FWD_DOWN) || (state_q == ST_EOP_DOWN) ||
                     (state_q == ST_BUS_RST);
      oe_up       <= (state_q == ST_FWD_UP) || (state_q == ST_EOP_UP);
      busy        <= (state_q != ST_IDLE);
      bus_reset   <= (state_q == ST_BUS_RST);
      err_timeout <= abort_q;
      state_o     <= state_q;
    end
  end

`ifdef USB_DIR_ARBITER_STATS_EN
  logic [15:0] pkt_down_q, pkt_up_q;

  // Count completed packets on entry to the EOP states; aborts never get here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_down_q <= '0;
      pkt_up_q   <= '0;
    end else begin
      if (state_d == ST_EOP_DOWN && state_q != ST_EOP_DOWN) pkt_down_q <= pkt_down_q + 1'b1;
      if (state_d == ST_EOP_UP && state_q != ST_EOP_UP)     pkt_up_q   <= pkt_up_q + 1'b1;
    end
  end

  assign pkt_down_cnt = pkt_down_q;
  assign pkt_up_cnt   = pkt_up_q;
`endif

endmodule

// File: tb/tb_usb_dir_arbiter.sv
// Directed bench for usb_dir_arbiter with hand-computed cycle expectations.
// Inputs change 1 ns after a rising edge; "edge 0" is the next rising edge.
module tb_usb_dir_arbiter;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_dp_i = 1'b1, host_dm_i = 1'b0;
  logic       dev_dp_i = 1'b1, dev_dm_i = 1'b0;
  logic       oe_down, oe_up, busy, bus_reset, err_timeout;
  logic [2:0] state_o;
`ifdef USB_DIR_ARBITER_STATS_EN
  logic [15:0] pkt_down_cnt, pkt_up_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  always #10 clk = ~clk;

  usb_dir_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .host_dp_i   (host_dp_i),
    .host_dm_i   (host_dm_i),
    .dev_dp_i    (dev_dp_i),
    .dev_dm_i    (dev_dm_i),
    .oe_down     (oe_down),
    .oe_up       (oe_up),
    .busy        (busy),
    .bus_reset   (bus_reset),
    .err_timeout (err_timeout),
    .state_o     (state_o)
`ifdef USB_DIR_ARBITER_STATS_EN
    ,
    .pkt_down_cnt(pkt_down_cnt),
    .pkt_up_cnt  (pkt_up_cnt)
`endif
  );

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_host(input logic [1:0] l);
    {host_dp_i, host_dm_i} = l;
  endtask

  task automatic set_dev(input logic [1:0] l);
    {dev_dp_i, dev_dm_i} = l;
  endtask

  // One clean packet from the given side: K start, SE0 run, then J.
  task automatic run_pkt(input bit up, input int se0_len);
    if (up) set_dev(K); else set_host(K);
    step(4);
    chk(up ? "up_pre_rise" : "down_pre_rise", up ? oe_up : oe_down, 0);
    step(1);
    chk(up ? "up_rise" : "down_rise", up ? oe_up : oe_down, 1);
    chk("other_oe_off", up ? oe_down : oe_up, 0);
    chk("fwd_state", state_o, up ? 3 : 1);
    step(6);
    if (up) set_dev(SE0); else set_host(SE0);
    step(se0_len);
    if (up) set_dev(J); else set_host(J);
    step(7);
    chk("eop_hold", up ? oe_up : oe_down, 1);
    chk("eop_state", state_o, up ? 4 : 2);
    step(1);
    chk("eop_fall", up ? oe_up : oe_down, 0);
    step(7);
    chk("turn_busy", busy, 1);
    step(1);
    chk("idle_busy", busy, 0);
    chk("idle_state", state_o, 0);
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_oe_down", oe_down, 0);
    chk("rst_oe_up", oe_up, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_reset", bus_reset, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;
    step(5);

    // Downstream packet with an 8-cycle SE0 EOP
    run_pkt(1'b0, 8);

    // Both sides start together: host wins
    set_host(K);
    set_dev(K);
    step(4);
    chk("both_pre_rise", oe_down, 0);
    step(1);
    chk("both_down", oe_down, 1);
    chk("both_up_off", oe_up, 0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("both_up_stays_off", oe_up, 0);
    end
    set_dev(J);
    step(3);
    set_host(SE0);
    step(4);
    set_host(J);
    step(7);
    chk("both_eop_hold", oe_down, 1);
    chk("both_eop_up_off", oe_up, 0);
    step(1);
    chk("both_eop_fall", oe_down, 0);
    step(8);
    chk("both_idle", busy, 0);

    // Host bus reset: 200 cycles of SE0
    set_host(SE0);
    step(127);
    chk("busrst_pre", bus_reset, 0);
    step(1);
    chk("busrst_on", bus_reset, 1);
    chk("busrst_oe_down", oe_down, 1);
    chk("busrst_state", state_o, 6);
    step(72);
    chk("busrst_held", bus_reset, 1);
    set_host(J);
    step(3);
    chk("busrst_before_j", bus_reset, 1);
    step(1);
    chk("busrst_off", bus_reset, 0);
    chk("busrst_oe_off", oe_down, 0);
    chk("busrst_turn", state_o, 5);
    step(7);
    chk("busrst_turn_busy", busy, 1);
    step(1);
    chk("busrst_idle", busy, 0);

    // Device packet with a 2-cycle SE0 glitch, then a 6-cycle SE0 EOP
    set_dev(K);
    step(4);
    chk("glitch_pre_rise", oe_up, 0);
    step(1);
    chk("glitch_rise", oe_up, 1);
    step(5);
    set_dev(SE0);
    step(2);
    set_dev(J);
    step(2);
    set_dev(K);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("glitch_oe_up_held", oe_up, 1);
    end
    set_dev(SE0);
    step(6);
    set_dev(J);
    step(7);
    chk("glitch_eop_hold", oe_up, 1);
    step(1);
    chk("glitch_eop_fall", oe_up, 0);
    step(8);
    chk("glitch_idle", busy, 0);

    // Asynchronous reset in the middle of an upstream packet
    set_dev(K);
    step(5);
    chk("arst_fwd_up", oe_up, 1);
    chk("arst_fwd_state", state_o, 3);
    step(3);
    #3;
    rst = 1'b1;
    set_dev(J);
    #1;
    chk("arst_oe_up", oe_up, 0);
    chk("arst_state", state_o, 0);
    chk("arst_busy", busy, 0);
`ifdef USB_DIR_ARBITER_STATS_EN
    chk("arst_cnt_down", pkt_down_cnt, 0);
    chk("arst_cnt_up", pkt_up_cnt, 0);
`endif
    step(2);
    rst = 1'b0;
    step(5);
    chk("arst_after_idle", busy, 0);

    // Three downstream and two upstream packets (SE0 of exactly SE0_MIN included)
    run_pkt(1'b0, 3);
    run_pkt(1'b1, 4);
    run_pkt(1'b0, 5);
    run_pkt(1'b1, 3);
    run_pkt(1'b0, 6);
`ifdef USB_DIR_ARBITER_STATS_EN
    chk("stats_down", pkt_down_cnt, 3);
    chk("stats_up", pkt_up_cnt, 2);
`endif

    // Runaway host packet: enable held exactly MAX_PKT cycles, then abort
    set_host(K);
    n = 0;
    do begin
      step(1);
      n++;
    end while (err_timeout !== 1'b1 && n < 50100);
    chk("timeout_latency", n, 50005);
    chk("timeout_oe_down", oe_down, 0);
    chk("timeout_turn", state_o, 5);
    set_host(J);
    step(1);
    chk("timeout_single_pulse", err_timeout, 0);
    step(20);
    chk("timeout_idle_busy", busy, 0);
    chk("timeout_idle_state", state_o, 0);
    chk("timeout_idle_oe", oe_down, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
